// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the stage sequencer
package seq_pkg;

   typedef enum logic [1:0] {
      SEQ_RUN   = 2'd0,
      SEQ_DRAIN = 2'd1,
      SEQ_DONE  = 2'd2
   } seq_state_t;

   localparam int DEFAULT_FLAG_W = 5;

   // bit positions within the ALU flag vector
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_EQUAL = 1;
   localparam int FLAG_GT    = 2;
   localparam int FLAG_LT    = 3;
   localparam int FLAG_CARRY = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (en && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle stage sequencer with stall, drain/halt, flag/mode capture and perf counters
module stage_sequencer
   import seq_pkg::*;
#(
   parameter int             NUM_STAGES = 4,
   parameter int             SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
   parameter int             D          = 12,
   parameter int             FLAG_W     = DEFAULT_FLAG_W,
   parameter int             FLAG_STAGE = 2,
   parameter logic [D-1:0]   DONE_ADDR  = {D{1'b1}},
   parameter int             CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  halt_req,
   input  logic [D-1:0]          prog_ctr,
   input  logic [FLAG_W-1:0]     flags_in,
   input  logic                  flag_we,
   input  logic                  mode_next,
   input  logic                  mode_we,
   output logic [SW-1:0]         stage,
   output logic [NUM_STAGES-1:0] stage_onehot,
   output logic                  last_stage,
   output logic [FLAG_W-1:0]     flags_q,
   output logic                  mode_q,
   output logic                  done,
   output logic [CNT_W-1:0]      cycle_count,
   output logic [CNT_W-1:0]      instr_count
);

   if (NUM_STAGES < 1 || FLAG_STAGE >= NUM_STAGES) begin : g_bad_params
      $error("stage_sequencer: NUM_STAGES must be >= 1 and FLAG_STAGE < NUM_STAGES");
   end

   localparam logic [SW-1:0] LAST_IDX = SW'(NUM_STAGES - 1);
   localparam logic [SW-1:0] FLAG_IDX = SW'(FLAG_STAGE);

   seq_state_t    state, state_next;
   logic [SW-1:0] stage_next;
   logic          halt_pending, halt_pending_next;
   logic          active, retire, drain_req, flag_cap;

   assign active       = (state != SEQ_DONE);
   assign last_stage   = (stage == LAST_IDX);
   assign retire       = last_stage && !stall && active;
   assign flag_cap     = (stage == FLAG_IDX) && !stall && flag_we && active;
   assign stage_onehot = NUM_STAGES'(1) << stage;
   assign done         = (state == SEQ_DONE);

   // the drain condition is sticky once seen; DRAIN itself keeps it asserted
   assign drain_req = halt_req || (prog_ctr == DONE_ADDR) || halt_pending
                      || (state == SEQ_DRAIN);

   always_comb begin
      state_next        = state;
      stage_next        = stage;
      halt_pending_next = halt_pending;
      case (state)
         SEQ_RUN, SEQ_DRAIN: begin
            if (halt_req && stall)
               halt_pending_next = 1'b1;
            if (!stall)
               stage_next = last_stage ? '0 : stage + SW'(1);
            if (drain_req && retire) begin
               state_next = SEQ_DONE;
               stage_next = '0;
            end else if (drain_req) begin
               state_next = SEQ_DRAIN;
            end
         end
         default: begin
            state_next = SEQ_DONE;
            stage_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= SEQ_RUN;
         stage        <= '0;
         halt_pending <= 1'b0;
         flags_q      <= '0;
         mode_q       <= 1'b0;
      end else begin
         state        <= state_next;
         stage        <= stage_next;
         halt_pending <= halt_pending_next;
         if (flag_cap)
            flags_q <= flags_in;
         if (retire && mode_we)
            mode_q <= mode_next;
      end
   end

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .clear (reset),
      .en    (active),
      .count (cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .clear (reset),
      .en    (retire),
      .count (instr_count)
   );

endmodule
